// File: rtl/xif_pkg.sv
// Shared types and default widths for the XIF offload controller.
package xif_pkg;

  localparam int XIF_ID_W    = 4;
  localparam int XIF_XLEN    = 32;
  localparam int XIF_MAX_OUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT
  } state_t;

  typedef struct packed {
    logic [31:0]          instr;
    logic [XIF_ID_W-1:0]  id;
    logic [XIF_XLEN-1:0]  rs1;
  } xif_issue_t;

  typedef struct packed {
    logic [XIF_ID_W-1:0]  id;
    logic [XIF_XLEN-1:0]  data;
    logic [4:0]           rd;
    logic                 we;
  } xif_result_t;

endpackage

// File: rtl/xif_id_scoreboard.sv
// Outstanding-ID bitmap with one set port, two clear ports, two lookups and a popcount.
module xif_id_scoreboard #(
  parameter int ID_W = 4
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            set_en,
  input  logic [ID_W-1:0] set_id,
  input  logic            clr_a_en,
  input  logic [ID_W-1:0] clr_a_id,
  input  logic            clr_b_en,
  input  logic [ID_W-1:0] clr_b_id,
  input  logic [ID_W-1:0] look_a_id,
  output logic            look_a_hit,
  input  logic [ID_W-1:0] look_b_id,
  output logic            look_b_hit,
  output logic [ID_W:0]   count
);

  localparam int N = 2 ** ID_W;

  logic [N-1:0] bits;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)   set_mask[set_id]   = 1'b1;
    if (clr_a_en) clr_mask[clr_a_id] = 1'b1;
    if (clr_b_en) clr_mask[clr_b_id] = 1'b1;
  end

  // Set and clear never target the same ID in one edge, so ordering is immaterial.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) bits <= '0;
    else      bits <= (bits & ~clr_mask) | set_mask;
  end

  assign look_a_hit = bits[look_a_id];
  assign look_b_hit = bits[look_b_id];

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + {{ID_W{1'b0}}, bits[i]};
  end

endmodule

// File: rtl/xif_offload_ctrl.sv
// Core-side XIF initiator: allocates IDs, runs issue/commit handshakes, returns writebacks.
//   state  | meaning
//   IDLE   | waiting for an instruction from the core
//   ISSUE  | issue request held until the coprocessor samples it
//   COMMIT | one-cycle commit (or kill) of the issued ID
module xif_offload_ctrl
  import xif_pkg::*;
#(
  parameter int X_ID_WIDTH      = XIF_ID_W,
  parameter int MAX_OUTSTANDING = XIF_MAX_OUT,
  parameter int XLEN            = XIF_XLEN
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic                  flush,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [31:0]           issue_instr,
  output logic [X_ID_WIDTH-1:0] issue_id,
  output logic [XLEN-1:0]       issue_rs1,
  input  logic                  issue_accept,
  output logic                  commit_valid,
  output logic [X_ID_WIDTH-1:0] commit_id,
  output logic                  commit_kill,
  input  logic                  result_valid,
  output logic                  result_ready,
  input  logic [X_ID_WIDTH-1:0] result_id,
  input  logic [XLEN-1:0]       result_data,
  input  logic [4:0]            result_rd,
  input  logic                  result_we,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  illegal_instr,
  output logic                  protocol_err,
  output logic [X_ID_WIDTH:0]   outstanding_cnt
);

  localparam logic [X_ID_WIDTH:0] MAX_CNT = (X_ID_WIDTH + 1)'(MAX_OUTSTANDING);

  state_t                state;
  state_t                state_nxt;
  logic [X_ID_WIDTH-1:0] next_id;
  xif_issue_t            iss;
  xif_result_t           res;
  logic                  run_q;
  logic                  illegal_q;
  logic                  perr_q;
  logic                  wb_valid_q;
  logic [4:0]            wb_rd_q;
  logic [XLEN-1:0]       wb_data_q;
  logic                  next_busy;
  logic                  res_hit;
  logic                  take;
  logic                  hs_accept;
  logic                  hs_reject;
  logic                  res_fire;
  logic                  kill;

  assign res       = '{id: result_id, data: result_data, rd: result_rd, we: result_we};
  assign take      = instr_valid && instr_ready;
  assign hs_accept = (state == ISSUE) && issue_ready && issue_accept;
  assign hs_reject = (state == ISSUE) && issue_ready && !issue_accept;
  assign res_fire  = result_valid && run_q;
  assign kill      = (state == COMMIT) && flush;

  // Lookups use the pre-edge bitmap: a result for the ID issued this cycle is unknown.
  xif_id_scoreboard #(.ID_W(X_ID_WIDTH)) u_sb (
    .ck         (ck),
    .rst        (rst),
    .set_en     (hs_accept),
    .set_id     (iss.id),
    .clr_a_en   (res_fire && res_hit),
    .clr_a_id   (res.id),
    .clr_b_en   (kill),
    .clr_b_id   (iss.id),
    .look_a_id  (next_id),
    .look_a_hit (next_busy),
    .look_b_id  (res.id),
    .look_b_hit (res_hit),
    .count      (outstanding_cnt)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   if (issue_ready) state_nxt = issue_accept ? COMMIT : IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = run_q && (state == IDLE) && (outstanding_cnt < MAX_CNT) && !next_busy;
    issue_valid  = (state == ISSUE);
    commit_valid = (state == COMMIT);
    commit_kill  = kill;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      next_id    <= '0;
      iss        <= '0;
      illegal_q  <= 1'b0;
      perr_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      run_q      <= 1'b1;
      illegal_q  <= hs_reject;
      perr_q     <= res_fire && !res_hit;
      wb_valid_q <= res_fire && res_hit && res.we;
      if (take) iss <= '{instr: instr, id: next_id, rs1: rs1_data};
      if (hs_accept) next_id <= next_id + 1'b1;
      if (res_fire && res_hit && res.we) begin
        wb_rd_q   <= res.rd;
        wb_data_q <= res.data;
      end
    end
  end

  assign result_ready  = run_q;
  assign issue_instr   = iss.instr;
  assign issue_id      = iss.id;
  assign issue_rs1     = iss.rs1;
  assign commit_id     = iss.id;
  assign illegal_instr = illegal_q;
  assign protocol_err  = perr_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Randomized scoreboard bench for xif_offload_ctrl against a bitmap/queue reference model.
module tb_xif_offload_ctrl;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0, instr_ready;
  logic [31:0] instr = '0, rs1_data = '0;
  logic        flush = 1'b0;
  logic        issue_valid, issue_ready = 1'b0, issue_accept = 1'b0;
  logic [31:0] issue_instr, issue_rs1;
  logic [3:0]  issue_id, commit_id;
  logic        commit_valid, commit_kill;
  logic        result_valid = 1'b0, result_ready, result_we = 1'b0;
  logic [3:0]  result_id = '0;
  logic [31:0] result_data = '0;
  logic [4:0]  result_rd = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_instr, protocol_err;
  logic [4:0]  outstanding_cnt;

  xif_offload_ctrl dut (
    .ck(ck), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_data(rs1_data), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_id(issue_id), .issue_rs1(issue_rs1),
    .issue_accept(issue_accept), .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_kill(commit_kill), .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_data(result_data), .result_rd(result_rd),
    .result_we(result_we), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal_instr(illegal_instr), .protocol_err(protocol_err),
    .outstanding_cnt(outstanding_cnt)
  );

  always #5 ck = ~ck;

  typedef struct { logic [31:0] instr; logic [3:0] id; logic [31:0] rs1; } iss_t;
  typedef struct { logic [3:0] id; logic kill; } com_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  int   checks = 0, errors = 0;
  iss_t iss_q[$];
  com_t com_q[$];
  wb_t  wb_q[$];
  int   exp_ill = 0, exp_perr = 0;
  bit   m_out[16];
  int   m_nid = 0;
  iss_t ei;
  com_t ec;
  wb_t  ew;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_out[i]);
    return c;
  endfunction

  function automatic bit m_ready();
    return (m_cnt() < 8) && !m_out[m_nid];
  endfunction

  // Every expectation except issue is due at the first negedge after it is pushed.
  always @(negedge ck) if (rst) begin
    if (issue_valid && issue_ready) begin
      if (iss_q.size() == 0) chk("issue_unexpected", 64'(iss_q.size()), 1);
      else begin
        ei = iss_q.pop_front();
        chk("issue_instr", issue_instr, ei.instr);
        chk("issue_id", issue_id, ei.id);
        chk("issue_rs1", issue_rs1, ei.rs1);
      end
    end
    if (com_q.size() > 0) begin
      ec = com_q.pop_front();
      chk("commit_valid", commit_valid, 1);
      chk("commit_id", commit_id, ec.id);
      chk("commit_kill", commit_kill, ec.kill);
    end else chk("commit_idle", commit_valid, 0);
    if (wb_q.size() > 0) begin
      ew = wb_q.pop_front();
      chk("wb_valid", wb_valid, 1);
      chk("wb_rd", wb_rd, ew.rd);
      chk("wb_data", wb_data, ew.data);
    end else chk("wb_idle", wb_valid, 0);
    if (exp_ill > 0) begin exp_ill--; chk("illegal_instr", illegal_instr, 1); end
    else chk("illegal_idle", illegal_instr, 0);
    if (exp_perr > 0) begin exp_perr--; chk("protocol_err", protocol_err, 1); end
    else chk("perr_idle", protocol_err, 0);
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk_cnt();
    @(negedge ck);
    chk("outstanding_cnt", outstanding_cnt, 64'(m_cnt()));
    tick();
  endtask

  task automatic do_result(input int id, input logic [4:0] rd, input logic [31:0] d, input bit we);
    bit known = m_out[id];
    result_valid = 1'b1; result_id = id[3:0]; result_rd = rd; result_data = d; result_we = we;
    tick();
    result_valid = 1'b0;
    if (known) begin
      m_out[id] = 1'b0;
      if (we) wb_q.push_back('{rd, d});
    end else exp_perr++;
  endtask

  task automatic retire_random(input int excl);
    int c[$];
    for (int i = 0; i < 16; i++) if (m_out[i] && i != excl) c.push_back(i);
    if (c.size() == 0) return;
    do_result(c[$urandom_range(c.size() - 1)], 5'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic do_instr(input logic [31:0] in, input logic [31:0] rs, input bit acc,
                          input int rdly, input bit fl, input int cres);
    int n = 0;
    logic [3:0] id;
    bit known = 1'b0;
    logic [4:0] rrd = 5'($urandom);
    logic [31:0] rdat = $urandom;
    bit rwe = 1'($urandom);
    instr_valid = 1'b1; instr = in; rs1_data = rs;
    forever begin
      @(negedge ck);
      chk("instr_ready", instr_ready, m_ready());
      if (instr_ready) break;
      n++;
      if (n > 40) begin
        chk("ready_timeout", 64'(n), 0);
        tick();
        instr_valid = 1'b0;
        return;
      end
      tick();
    end
    id = 4'(m_nid);
    iss_q.push_back('{in, id, rs});
    tick();
    instr_valid = 1'b0; instr = $urandom; rs1_data = $urandom;
    for (int i = 0; i < rdly; i++) begin
      @(negedge ck);
      chk("held_valid", issue_valid, 1);
      chk("held_id", issue_id, id);
      chk("held_instr", issue_instr, in);
      chk("held_rs1", issue_rs1, rs);
      tick();
    end
    issue_ready = 1'b1; issue_accept = acc;
    if (cres >= 0) begin
      known = m_out[cres];
      result_valid = 1'b1; result_id = 4'(cres); result_rd = rrd; result_data = rdat;
      result_we = rwe;
    end
    tick();
    issue_ready = 1'b0; issue_accept = 1'b0; result_valid = 1'b0;
    if (cres >= 0) begin
      if (known) begin
        m_out[cres] = 1'b0;
        if (rwe) wb_q.push_back('{rrd, rdat});
      end else exp_perr++;
    end
    if (acc) begin
      m_out[id] = 1'b1;
      m_nid = (m_nid + 1) % 16;
      com_q.push_back('{id, fl});
      flush = fl;
      @(negedge ck);
      chk("cnt_in_commit", outstanding_cnt, 64'(m_cnt()));
      tick();
      flush = 1'b0;
      if (fl) m_out[id] = 1'b0;
    end else exp_ill++;
  endtask

  task automatic drain();
    while (m_cnt() > 0) retire_random(-1);
    chk_cnt();
  endtask

  initial begin
    #(400000);
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int id_k;
    int r;
    #3;
    chk("rst_result_ready", result_ready, 0);
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_cnt", outstanding_cnt, 0);
    chk("rst_wb_valid", wb_valid, 0);
    @(negedge ck);
    rst = 1'b1;
    tick();
    @(negedge ck);
    chk("result_ready_run", result_ready, 1);
    tick();

    // Reject, then basic flow reusing the unconsumed ID.
    do_instr($urandom, $urandom, 1'b0, 0, 1'b0, -1);
    do_instr(32'h00A5_8553, 32'h0000_1234, 1'b1, 0, 1'b0, -1);
    do_result(0, 5'd10, 32'h3F80_0000, 1'b1);
    chk_cnt();

    // Flush kills the commit; a late result for it is unknown.
    id_k = m_nid;
    do_instr($urandom, $urandom, 1'b1, 0, 1'b1, -1);
    chk_cnt();
    do_result(id_k, 5'd3, $urandom, 1'b1);

    // Backpressure.
    do_instr($urandom, $urandom, 1'b1, 5, 1'b0, -1);
    drain();

    // Full at eight outstanding; returning one re-enables issue.
    id_k = (m_nid + 3) % 16;
    for (int i = 0; i < 8; i++) do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk("full_ready", instr_ready, m_ready());
      tick();
    end
    do_result(id_k, 5'd7, $urandom, 1'b1);
    do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
    drain();

    // Wrap with out-of-order retirement while ID 0 stays outstanding.
    while (m_nid != 0) begin
      id_k = m_nid;
      do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
      do_result(id_k, 5'($urandom), $urandom, 1'b1);
    end
    for (int k = 0; k < 16; k++) begin
      do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
      while (m_cnt() >= 7) retire_random(0);
      if ($urandom_range(1) == 1) retire_random(0);
    end
    while (m_cnt() > 1) retire_random(0);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk("wrap_stall_ready", instr_ready, m_ready());
      tick();
    end
    do_result(0, 5'd1, $urandom, 1'b1);
    do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
    drain();

    // Random traffic, including results landing on the issue handshake cycle.
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(9);
      if (r < 6) begin
        while (!m_ready()) begin
          if (m_out[m_nid]) do_result(m_nid, 5'($urandom), $urandom, 1'($urandom));
          else retire_random(-1);
        end
        do_instr($urandom, $urandom, $urandom_range(99) < 85, $urandom_range(2),
                 $urandom_range(99) < 20,
                 ($urandom_range(99) < 30) ? int'($urandom_range(15)) : -1);
      end else if (r < 9) retire_random(-1);
      else do_result($urandom_range(15), 5'($urandom), $urandom, 1'($urandom));
      if (it % 10 == 0) chk_cnt();
    end
    drain();

    // Asynchronous reset while in ISSUE.
    do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
    instr_valid = 1'b1;
    @(negedge ck);
    chk("pre_reset_ready", instr_ready, m_ready());
    tick();
    instr_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_issue_valid", issue_valid, 0);
    chk("arst_issue_id", issue_id, 0);
    chk("arst_issue_instr", issue_instr, 0);
    chk("arst_instr_ready", instr_ready, 0);
    chk("arst_result_ready", result_ready, 0);
    chk("arst_cnt", outstanding_cnt, 0);
    chk("arst_commit", commit_valid, 0);
    chk("arst_wb", wb_valid, 0);
    for (int i = 0; i < 16; i++) m_out[i] = 1'b0;
    m_nid = 0;
    iss_q.delete();
    com_q.delete();
    wb_q.delete();
    exp_ill = 0;
    exp_perr = 0;
    @(negedge ck);
    rst = 1'b1;
    tick();
    tick();
    do_instr($urandom, $urandom, 1'b1, 0, 1'b0, -1);
    do_result(0, 5'd12, $urandom, 1'b1);
    chk_cnt();
    tick();

    chk("iss_q_empty", 64'(iss_q.size()), 0);
    chk("com_q_empty", 64'(com_q.size()), 0);
    chk("wb_q_empty", 64'(wb_q.size()), 0);
    chk("ill_pending", 64'(exp_ill), 0);
    chk("perr_pending", 64'(exp_perr), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
